// File: rtl/cache_backing_ctrl.sv
// Refill/eviction backing store: read FSM with configurable latency plus a write-back FIFO drained into a word array.
// Optional macro CACHE_BACKING_WB_FORWARD_EN lets reads hit pending buffer entries instead of waiting for the drain.
module cache_backing_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int MEM_WORDS      = 1024,
    parameter int WB_DEPTH       = 4,
    parameter int READ_LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      re_from_ram,
    input  logic [RAM_ADDR_WIDTH-1:0] r_addr,
    input  logic                      we_to_ram,
    input  logic [RAM_ADDR_WIDTH-1:0] w_addr_to_ram,
    input  logic [DATA_WIDTH-1:0]     wd_to_ram,
    output logic [DATA_WIDTH-1:0]     rd_from_ram,
    output logic                      rd_valid,
    output logic                      stall,
    output logic                      wb_overflow
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(WB_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        raddr_q, raddr_d;
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    ovf_q, ovf_d;
    logic [IDX_W-1:0]        wb_idx_q [WB_DEPTH];
    logic [DATA_WIDTH-1:0]   wb_dat_q [WB_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

    logic [IDX_W-1:0]        w_idx_s, r_idx_s, lookup_idx_s;
    logic [DATA_WIDTH-1:0]   lookup_data_s;
    logic                    empty_s, full_s, idle_s, stall_s;
    logic                    rd_accept_s, drain_s, push_s;
    logic                    unused_addr_s;
`ifdef CACHE_BACKING_WB_FORWARD_EN
    logic [PTR_W:0]          count_s;
    logic [PTR_W-1:0]        slot_s;
`endif

    assign w_idx_s       = w_addr_to_ram[IDX_W+1:2];
    assign r_idx_s       = r_addr[IDX_W+1:2];
    assign unused_addr_s = ^{r_addr[1:0], r_addr[RAM_ADDR_WIDTH-1:IDX_W+2],
                             w_addr_to_ram[1:0], w_addr_to_ram[RAM_ADDR_WIDTH-1:IDX_W+2]};

    // Request arbitration: a drain at full frees its slot before the push is judged
    always_comb begin
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
        idle_s  = (state_q == IDLE);
`ifdef CACHE_BACKING_WB_FORWARD_EN
        stall_s = full_s || !idle_s;
`else
        // Without forwarding a read waits until the buffer (and any same-cycle write) has landed
        stall_s = full_s || !idle_s || (re_from_ram && (!empty_s || we_to_ram));
`endif
        rd_accept_s = idle_s && re_from_ram && !stall_s;
        drain_s     = idle_s && !rd_accept_s && !empty_s;
        push_s      = we_to_ram && (!full_s || drain_s);
    end

    // Read data source: array word, optionally overridden by the newest pending write
    always_comb begin
        lookup_idx_s  = idle_s ? r_idx_s : raddr_q;
        lookup_data_s = mem_q[lookup_idx_s];
`ifdef CACHE_BACKING_WB_FORWARD_EN
        count_s = wr_ptr_q - rd_ptr_q;
        slot_s  = rd_ptr_q[PTR_W-1:0];
        for (int k = 0; k < WB_DEPTH; k++) begin
            slot_s = rd_ptr_q[PTR_W-1:0] + PTR_W'(k);
            if (((PTR_W+1)'(k) < count_s) && (wb_idx_q[slot_s] == lookup_idx_s)) begin
                lookup_data_s = wb_dat_q[slot_s];
            end else begin
                lookup_data_s = lookup_data_s;
            end
        end
        if (push_s && (w_idx_s == lookup_idx_s)) begin
            lookup_data_s = wd_to_ram;
        end else begin
            lookup_data_s = lookup_data_s;
        end
`endif
    end

    // Next-state logic for the read FSM and FIFO pointers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_s};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, drain_s};
        case (state_q)
            IDLE: begin
                if (rd_accept_s) begin
                    raddr_d = r_idx_s;
                    if (READ_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(READ_LATENCY - 2);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: data is captured on entry to RESP so it is stable while rd_valid is high
    always_comb begin
        rd_valid_d = (state_d == RESP);
        if (state_d == RESP) begin
            rd_data_d = lookup_data_s;
        end else begin
            rd_data_d = rd_data_q;
        end
        ovf_d = ovf_q || (we_to_ram && !push_s);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            raddr_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raddr_q    <= raddr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            wb_idx_q[wr_ptr_q[PTR_W-1:0]] <= w_idx_s;
            wb_dat_q[wr_ptr_q[PTR_W-1:0]] <= wd_to_ram;
        end
    end

    // Backing array keeps its contents across reset; only a live drain writes it
    always_ff @(posedge clk) begin
        if (drain_s && rst_n) begin
            mem_q[wb_idx_q[rd_ptr_q[PTR_W-1:0]]] <= wb_dat_q[rd_ptr_q[PTR_W-1:0]];
        end
    end

    assign rd_from_ram = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign stall       = stall_s;
    assign wb_overflow = ovf_q;
endmodule

// File: tb/tb_cache_backing_ctrl.sv
// Bench for cache_backing_ctrl: vector table, multi-cycle corner sequences and a randomized run
// against a queue-based reference model (three instances: read latency 2, 5 and 1).
module tb_cache_backing_ctrl;
`ifdef CACHE_BACKING_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_s [3];
    logic        re_s [3];
    logic        we_s [3];
    logic [31:0] ra_s [3];
    logic [31:0] wa_s [3];
    logic [31:0] wd_s [3];
    logic [31:0] rd_s [3];
    logic        rv_s [3];
    logic        st_s [3];
    logic        ov_s [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cache_backing_ctrl #(
            .READ_LATENCY(g == 0 ? 2 : (g == 1 ? 5 : 1))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n_s[g]),
            .re_from_ram  (re_s[g]),
            .r_addr       (ra_s[g]),
            .we_to_ram    (we_s[g]),
            .w_addr_to_ram(wa_s[g]),
            .wd_to_ram    (wd_s[g]),
            .rd_from_ram  (rd_s[g]),
            .rd_valid     (rv_s[g]),
            .stall        (st_s[g]),
            .wb_overflow  (ov_s[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int k, input bit rst, input bit we, input logic [31:0] wa,
                         input logic [31:0] wd, input bit re, input logic [31:0] ra);
        rst_n_s[k] = rst;
        we_s[k]    = we;
        wa_s[k]    = wa;
        wd_s[k]    = wd;
        re_s[k]    = re;
        ra_s[k]    = ra;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold the current request until it is accepted, then wait for the response.
    task automatic read_wait(input int k, input logic [31:0] exp, input string nm);
        bit acc;
        bit got;
        acc = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = !st_s[k];
            cyc();
            we_s[k] = 1'b0;
            if (acc) re_s[k] = 1'b0;
        end
        chk({nm, "_accept"}, 32'(acc), 32'd1);
        for (int n = 0; n < 20 && !got; n++) begin
            if (rv_s[k]) got = 1'b1;
            else cyc();
        end
        chk({nm, "_valid"}, 32'(got), 32'd1);
        chk({nm, "_data"}, rd_s[k], exp);
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          re;
        logic [31:0] ra;
        bit          cs;
        bit          es;
        bit          ev;
        logic [31:0] ed;
        bit          eo;
    } vec_t;

    function automatic vec_t mkv(bit rst, bit we, logic [31:0] wa, logic [31:0] wd, bit re,
                                 logic [31:0] ra, bit cs, bit es, bit ev, logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.cs = cs; v.es = es; v.ev = ev; v.ed = ed; v.eo = 1'b0;
        return v;
    endfunction

    // Reference model for instance 0: pending writes as a queue, read in flight as a countdown.
    typedef struct { int idx; logic [31:0] dat; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_mem [int];
    int          m_pend = 0;
    int          m_ridx = 0;
    logic        m_rv = 1'b0;
    logic [31:0] m_rd = 32'd0;
    logic        m_ov = 1'b0;

    function automatic logic [31:0] lookup(int idx);
        logic [31:0] v;
        v = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
        if (FWD) begin
            foreach (m_q[i]) if (m_q[i].idx == idx) v = m_q[i].dat;
        end
        return v;
    endfunction

    task automatic model_cycle(input bit rst, input bit we, input logic [31:0] wa,
                               input logic [31:0] wd, input bit re, input logic [31:0] ra);
        bit   idle, full, st, acc, drn, psh;
        ent_t e;
        drive(0, rst, we, wa, wd, re, ra);
        idle = (m_pend == 0);
        full = (m_q.size() == 4);
        st   = full || !idle || (!FWD && re && (m_q.size() != 0 || we));
        acc  = idle && re && !st;
        drn  = idle && !acc && (m_q.size() != 0);
        psh  = we && (!full || drn);
        @(negedge clk);
        chk("rnd_stall", 32'(st_s[0]), 32'(st));
        cyc();
        if (!rst) begin
            m_q.delete();
            m_pend = 0;
            m_rv   = 1'b0;
            m_rd   = 32'd0;
            m_ov   = 1'b0;
        end else begin
            if (drn) begin
                e = m_q.pop_front();
                m_mem[e.idx] = e.dat;
            end
            if (psh) begin
                e.idx = int'(wa[11:2]);
                e.dat = wd;
                m_q.push_back(e);
            end
            if (we && !psh) m_ov = 1'b1;
            if (m_pend > 0) m_pend--;
            if (acc) begin
                m_pend = 2;
                m_ridx = int'(ra[11:2]);
            end
            m_rv = (m_pend == 1);
            if (m_rv) m_rd = lookup(m_ridx);
        end
        chk("rnd_valid", 32'(rv_s[0]), 32'(m_rv));
        chk("rnd_data", rd_s[0], m_rd);
        chk("rnd_ovf", 32'(ov_s[0]), 32'(m_ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] a;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        for (int k = 1; k < 3; k++) drive(k, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Single-beat write/read with latency 2, offset/MSB aliasing, and reset during WAIT
        tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1, 0, 0, 32'h0));
        for (int i = 0; i < 4; i++) tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 1, 32'h10, 1, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1, 1, 32'hDEADBEEF));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 1, 32'hF0000013, 1, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1, 1, 32'hDEADBEEF));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 1, 32'h10, 1, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 1, 32'h10, 1, 1, 0, 32'h0));
        tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0));
        foreach (tbl[i]) begin
            drive(0, tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
            @(negedge clk);
            if (tbl[i].cs) chk($sformatf("vec%0d_stall", i), 32'(st_s[0]), 32'(tbl[i].es));
            cyc();
            chk($sformatf("vec%0d_valid", i), 32'(rv_s[0]), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i), rd_s[0], tbl[i].ed);
            chk($sformatf("vec%0d_ovf", i), 32'(ov_s[0]), 32'(tbl[i].eo));
        end

        // Write and read of the same word presented together
        drive(0, 1'b1, 1'b1, 32'h20, 32'h11111111, 1'b1, 32'h20);
        read_wait(0, 32'h11111111, "same_cycle");

        // Two writes to one word, the newest must win
        drive(0, 1'b1, 1'b1, 32'h30, 32'hA, 1'b0, 32'h0);
        cyc();
        drive(0, 1'b1, 1'b1, 32'h30, 32'hB, 1'b1, 32'h30);
        read_wait(0, 32'hB, "newest_wins");

        // Latency-5 instance: fill the buffer behind a long read, overflow, then confirm the drop
        drive(1, 1'b1, 1'b1, 32'h50, 32'h12345678, 1'b0, 32'h0);
        cyc();
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cyc();
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h60);
        @(negedge clk);
        chk("fill_rd_accept", 32'(st_s[1]), 32'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
            cyc();
            chk($sformatf("fill%0d_ovf", i), 32'(ov_s[1]), 32'd0);
        end
        drive(1, 1'b1, 1'b1, 32'h50, 32'h55555555, 1'b0, 32'h0);
        @(negedge clk);
        chk("full_stall", 32'(st_s[1]), 32'd1);
        cyc();
        chk("overflow_set", 32'(ov_s[1]), 32'd1);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) cyc();
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h50);
        read_wait(1, 32'h12345678, "dropped_write");
        chk("overflow_sticky", 32'(ov_s[1]), 32'd1);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc();
        chk("overflow_reset", 32'(ov_s[1]), 32'd0);

        // Latency-1 instance with the read request held high
        drive(2, 1'b1, 1'b1, 32'h70, 32'hCAFEF00D, 1'b0, 32'h0);
        cyc();
        drive(2, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cyc();
        drive(2, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h70);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lat1_stall%0d", i), 32'(st_s[2]), (i == 1) ? 32'd1 : 32'd0);
            cyc();
            chk($sformatf("lat1_valid%0d", i), 32'(rv_s[2]), (i == 1) ? 32'd0 : 32'd1);
            chk($sformatf("lat1_data%0d", i), rd_s[2], 32'hCAFEF00D);
        end
        drive(2, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Randomized run on instance 0 against the model; words 0..7 are seeded first
        model_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) model_cycle(1'b1, 1'b1, 32'(4 * i), $urandom, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) model_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
            model_cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1,
                        ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2),
                        $urandom, $urandom_range(0, 2) == 0, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
